imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Bus-side responder (memory model) for the tagged load/store bus driven by the instruction-cache controller.
- Accepts one command per cycle and answers in the same cycle with a nonzero response tag, or 0 to reject.
- Returns the tag and data exactly LATENCY cycles later.
- Sits on the memory side of the fetch path and is also used as the bench memory for cache/controller verification.

Parameters:
- MEM_WORDS, 8192, number of 64-bit words; index = addr[3 +: log2(MEM_WORDS)]; addr[2:0] and upper bits ignored (wrap).
- LATENCY, 4, cycles from accept edge to tag/data presentation; legal range 1..31.
- NUM_TAGS, 15, usable tags 1..NUM_TAGS; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is synchronous and active-low (reset==0 resets on the rising edge of clock).
- proc2mem_addr  in  64  request byte address.
- proc2mem_data  in  64  store data.
- proc2mem_command  in  2  0=BUS_NONE, 1=BUS_LOAD, 2=BUS_STORE, 3=reserved (treated as NONE).
- mem2proc_response  out  4  combinational; accepted tag, 0 = not accepted.
- mem2proc_data  out  64  registered; load data valid while mem2proc_tag!=0.
- mem2proc_tag  out  4  registered; completing tag, 0 = none.

Behaviour:
- State:
  - tag_busy[NUM_TAGS:1];
  - LATENCY-stage shift pipeline, each stage = {valid, tag[3:0], is_load, data[63:0]};
  - memory array MEM_WORDS x 64.
- Response (combinational):
  - nonzero when reset==1, command is LOAD or STORE, and any tag is free.
  - Value = lowest-numbered free tag.
  - Depends only on command, reset and tag_busy; never on addr or data. Consumers feed the response back into the address path, so this rule prevents a combinational loop.
- Accept, at the edge ending cycle T with response R!=0:
  - tag_busy[R] set.
  - Pipeline stage 0 loaded with {1, R, is_load, payload}.
  - LOAD: payload = mem[index], the value before any store written at this same edge.
  - STORE: mem[index] <= proc2mem_data at this edge; payload = 0.
- Pipeline:
  - advances every cycle; no stall or backpressure.
  - At the edge ending cycle T+LATENCY-1, the last stage registers into mem2proc_tag/mem2proc_data.
  - Outputs therefore hold tag R during cycle T+LATENCY only, then return to tag 0, data 0 unless another completion follows back-to-back.
- Tag release:
  - tag_busy[R] clears at the edge ending the cycle in which R is presented on mem2proc_tag; R is reusable from the next cycle.
  - A tag being presented is never offered in the same cycle.
- Ordering and throughput:
  - fixed latency; completions occur in acceptance order, at most one per cycle.
  - max outstanding = min(NUM_TAGS, LATENCY+1).
- Exhaustion: all tags busy -> response 0; the request is dropped and the requester must re-issue. No memory write occurs for a rejected store.
- Load/store ordering:
  - a load accepted in a later cycle than a store to the same word returns the stored data.
  - load and store cannot be accepted in the same cycle (one command port).
- Reset (reset==0 at an edge):
  - pipeline valids cleared, tag_busy cleared, mem2proc_tag=0, mem2proc_data=0.
  - mem2proc_response forced 0 while reset==0.
  - Memory contents are not reset.
  - Reset mid-operation discards all in-flight completions; none are presented after reset deasserts.
- Reserved command 3 -> response 0, no state change.

Test Plan:
- LATENCY=4; preload mem[2]=64'hDEAD_BEEF_0000_0555; LOAD addr 0x10 in cycle 5 -> response 1 in cycle 5; tag 1, data 64'hDEADBEEF00000555 in cycle 9 only; tag 0 in cycle 10.
- LATENCY=4: LOAD every cycle, addresses 0x0,0x8,...,0x40 starting cycle 0 -> responses 1,2,3,4,5,1,... (tag 1 reused cycle 5, the cycle after its presentation in cycle 4); tags returned in order, each 4 cycles after accept.
- LATENCY=20, NUM_TAGS=15: LOAD every cycle from cycle 0 -> responses 1..15 in cycles 0-14, 0 in cycles 15-20; response 1 again in cycle 21 after tag 1 is presented in cycle 20.
- STORE 64'h1234 to 0x18 in cycle 3, LOAD 0x18 in cycle 4 -> load tag presented in cycle 8 with data 64'h1234; store tag presented in cycle 7 with data 0.
- 3 LOADs accepted in cycles 0-2, reset==0 in cycle 3, released in cycle 4 -> mem2proc_tag stays 0 in cycles 4-8; new LOAD in cycle 5 gets response 1; memory contents unchanged.
- Command held LOAD while reset==0 -> response 0 throughout; command=3 -> response 0 and no completion.

Source files
------------

// File: rtl/imem_responder.sv
// Fixed-latency tagged memory responder for the instruction-fetch bus.
// Accepts one command per cycle, answers with the lowest free tag, completes LATENCY cycles later.
module imem_responder #(
  parameter int MEM_WORDS = 8192,
  parameter int LATENCY   = 4,
  parameter int NUM_TAGS  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  input  logic [1:0]  proc2mem_command,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [NUM_TAGS:1] tag_busy_r;
  logic [NUM_TAGS:1] set_mask_s;
  logic [NUM_TAGS:1] clr_mask_s;
  logic [3:0]        stage_tag_r  [LATENCY];
  logic [63:0]       stage_data_r [LATENCY];
  logic [63:0]       mem_r        [MEM_WORDS];

  logic [IDX_W-1:0] idx_s;
  logic             req_s;
  logic             is_load_s;
  logic [3:0]       resp_s;
  logic             accept_s;
  logic [63:0]      payload_s;
  logic             addr_unused_s;

  assign idx_s         = proc2mem_addr[3 +: IDX_W];
  assign addr_unused_s = ^{proc2mem_addr[63:3+IDX_W], proc2mem_addr[2:0]};

  // Command decode; reserved encoding behaves like BUS_NONE.
  always_comb begin
    req_s     = 1'b0;
    is_load_s = 1'b0;
    case (proc2mem_command)
      BUS_LOAD: begin
        req_s     = 1'b1;
        is_load_s = 1'b1;
      end
      BUS_STORE: begin
        req_s     = 1'b1;
        is_load_s = 1'b0;
      end
      default: begin
        req_s     = 1'b0;
        is_load_s = 1'b0;
      end
    endcase
  end

  // Lowest free tag; deliberately independent of address/data so requesters may loop it back.
  always_comb begin
    resp_s = 4'd0;
    if (reset && req_s) begin
      for (int t = NUM_TAGS; t >= 1; t--) begin
        resp_s = tag_busy_r[t] ? resp_s : 4'(t);
      end
    end else begin
      resp_s = 4'd0;
    end
  end

  assign mem2proc_response = resp_s;
  assign accept_s          = (resp_s != 4'd0);
  assign payload_s         = is_load_s ? mem_r[idx_s] : 64'd0;

  // Tags claimed this cycle and tags whose completion is being presented this cycle.
  always_comb begin
    set_mask_s = {NUM_TAGS{1'b0}};
    clr_mask_s = {NUM_TAGS{1'b0}};
    for (int t = 1; t <= NUM_TAGS; t++) begin
      set_mask_s[t] = (resp_s == 4'(t));
      clr_mask_s[t] = (mem2proc_tag == 4'(t));
    end
  end

  // Completion pipeline and tag bookkeeping; the last stage doubles as the output register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_busy_r <= {NUM_TAGS{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        stage_tag_r[i]  <= 4'd0;
        stage_data_r[i] <= 64'd0;
      end
    end else begin
      tag_busy_r      <= (tag_busy_r | set_mask_s) & ~clr_mask_s;
      stage_tag_r[0]  <= resp_s;
      stage_data_r[0] <= accept_s ? payload_s : 64'd0;
      for (int i = 1; i < LATENCY; i++) begin
        stage_tag_r[i]  <= stage_tag_r[i-1];
        stage_data_r[i] <= stage_data_r[i-1];
      end
    end
  end

  // Backing store; never reset, written only by accepted stores.
  always_ff @(posedge clock) begin
    if (accept_s && !is_load_s) begin
      mem_r[idx_s] <= proc2mem_data;
    end
  end

  assign mem2proc_tag  = stage_tag_r[LATENCY-1];
  assign mem2proc_data = stage_data_r[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: driver pushes expected completions, monitor pops and compares.
module tb_imem_responder;

  localparam int LAT = 4;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;
  localparam logic [1:0] C_RSVD  = 2'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  cmd;
  logic [3:0]  resp;
  logic [63:0] rdata;
  logic [3:0]  tag;

  logic        reset2;
  logic [1:0]  cmd2;
  logic [3:0]  resp2;
  logic [63:0] rdata2;
  logic [3:0]  tag2;

  always #5 clock = ~clock;

  imem_responder #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .proc2mem_addr(addr), .proc2mem_data(wdata),
    .proc2mem_command(cmd), .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(tag)
  );

  imem_responder #(.LATENCY(20), .NUM_TAGS(15)) dut20 (
    .clock(clock), .reset(reset2), .proc2mem_addr(64'd0), .proc2mem_data(64'd0),
    .proc2mem_command(cmd2), .mem2proc_response(resp2), .mem2proc_data(rdata2), .mem2proc_tag(tag2)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [63:0] wv[9];
  int          bb[9] = '{1, 2, 3, 4, 5, 1, 2, 3, 4};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  // One bus cycle on the main DUT: check the same-cycle response, record the expected completion.
  task automatic drive(input logic rst, input logic [1:0] c, input logic [63:0] a,
                       input logic [63:0] d, input logic [3:0] er, input logic [63:0] ed);
    reset = rst;
    cmd   = c;
    addr  = a;
    wdata = d;
    @(negedge clock);
    chk($sformatf("response@%0d", cyc), 64'(resp), 64'(er));
    if (er != 4'd0) sbq.push_back('{er, ed, cyc + LAT});
    if (!rst) sbq.delete();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, C_NONE, 64'd0, 64'd0, 4'd0, 64'd0);
  endtask

  // Every cycle the outputs must show either the completion due now or tag 0 / data 0.
  always @(negedge clock) begin
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        chk($sformatf("tag@%0d", cyc), 64'(tag), 64'(sbq[0].tag));
        chk($sformatf("data@%0d", cyc), rdata, sbq[0].data);
        void'(sbq.pop_front());
      end else begin
        chk($sformatf("idle_tag@%0d", cyc), 64'(tag), 64'd0);
        chk($sformatf("idle_data@%0d", cyc), rdata, 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b0; cmd = C_NONE; addr = 64'd0; wdata = 64'd0;
    reset2 = 1'b0; cmd2 = C_NONE;
    for (int i = 0; i < 9; i++) wv[i] = (i == 2) ? 64'hDEAD_BEEF_0000_0555 : 64'hA000 + 64'(i);
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    // LOAD held during reset is never accepted
    drive(1'b0, C_LOAD, 64'h10, 64'd0, 4'd0, 64'd0);
    drive(1'b0, C_LOAD, 64'h10, 64'd0, 4'd0, 64'd0);

    // Back-to-back stores to words 0..8: tag 1 comes back the cycle after its presentation
    for (int i = 0; i < 9; i++) drive(1'b1, C_STORE, 64'(i * 8), wv[i], 4'(bb[i]), 64'd0);
    idle(6);

    // Single load of word 2
    drive(1'b1, C_LOAD, 64'h10, 64'd0, 4'd1, 64'hDEAD_BEEF_0000_0555);
    idle(6);

    // Back-to-back loads of words 0..8
    for (int i = 0; i < 9; i++) drive(1'b1, C_LOAD, 64'(i * 8), 64'd0, 4'(bb[i]), wv[i]);
    idle(6);

    // Store then load same word; aliased address with junk low/high bits maps to word 3 too
    drive(1'b1, C_STORE, 64'h18, 64'h1234, 4'd1, 64'd0);
    drive(1'b1, C_LOAD, 64'h18, 64'd0, 4'd2, 64'h1234);
    drive(1'b1, C_LOAD, 64'hFFFF_0000_0001_001F, 64'd0, 4'd3, 64'h1234);
    idle(6);

    // Reset with three loads in flight: nothing completes, memory survives
    drive(1'b1, C_LOAD, 64'h0, 64'd0, 4'd1, wv[0]);
    drive(1'b1, C_LOAD, 64'h8, 64'd0, 4'd2, wv[1]);
    drive(1'b1, C_LOAD, 64'h10, 64'd0, 4'd3, wv[2]);
    drive(1'b0, C_LOAD, 64'h10, 64'd0, 4'd0, 64'd0);
    idle(1);
    drive(1'b1, C_LOAD, 64'h8, 64'd0, 4'd1, wv[1]);
    idle(6);

    // Reserved command: no response, no completion, no write
    drive(1'b1, C_RSVD, 64'h8, 64'hBAD, 4'd0, 64'd0);
    drive(1'b1, C_RSVD, 64'h8, 64'hBAD, 4'd0, 64'd0);
    idle(5);
    drive(1'b1, C_LOAD, 64'h8, 64'd0, 4'd1, wv[1]);
    idle(6);

    // LATENCY=20 instance: tags exhaust after 15, tag 1 reused the cycle after it completes
    reset2 = 1'b1;
    cmd2   = C_LOAD;
    for (int k = 0; k < 22; k++) begin
      @(negedge clock);
      chk($sformatf("l20_resp@%0d", k), 64'(resp2),
          (k < 15) ? 64'(k + 1) : ((k == 21) ? 64'd1 : 64'd0));
      if (k == 19) chk("l20_tag@19", 64'(tag2), 64'd0);
      if (k == 20) chk("l20_tag@20", 64'(tag2), 64'd1);
      if (k == 21) chk("l20_tag@21", 64'(tag2), 64'd2);
      @(posedge clock);
      #1;
    end
    cmd2 = C_NONE;

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
